// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Avalon-MM slave that measures an external PWM waveform. It reports the
// period and the high time of the most recent complete PWM cycle, both in clk
// cycles. The period and high time returned together always come from the
// same PWM cycle: reading PERIOD snapshots HIGH into a shadow register, and
// reading HIGH returns that shadow.
//
// Register map (32-bit, word addressed):
//   0 CTRL   RW   bit0 enable, bit1 irq_en
//   1 STATUS W1C  bit0 valid, bit1 timeout (a set event beats a clear)
//   2 PERIOD RO   last captured period (zero-extended)
//   3 HIGH   RO   high time matching the last PERIOD read (shadow)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  qualifies read / write
//   read        read strobe (readdata loaded on this edge, latency 1)
//   write       write strobe
//   writedata   write data
//   readdata    registered read data
//   pwm_in      asynchronous PWM input under measurement
//   irq         level interrupt = STATUS.valid & CTRL.irq_en
// -----------------------------------------------------------------------------
module pwm_capture #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        pwm_in,
   output logic        irq
);

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrStatus = 2'd1;
   localparam logic [1:0] AddrPeriod = 2'd2;
   localparam logic [1:0] AddrHigh   = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StMeasure
   } state_e;

   // ---------------------------------------------------------------------------
   // Input synchronizer and rising-edge detect
   // ---------------------------------------------------------------------------
   logic r_sync1;
   logic r_s;
   logic r_s_d;
   logic w_rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_s     <= 1'b0;
         r_s_d   <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_s     <= r_sync1;
         r_s_d   <= r_s;
      end
   end

   assign w_rise = r_s & ~r_s_d;

   // ---------------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------------
   logic w_wr;
   logic w_rd;
   logic w_wr_ctrl;
   logic w_wr_status;
   logic w_rd_period;
   logic w_unused_wdata;

   assign w_wr        = chipselect & write;
   assign w_rd        = chipselect & read;
   assign w_wr_ctrl   = w_wr & (address == AddrCtrl);
   assign w_wr_status = w_wr & (address == AddrStatus);
   assign w_rd_period = w_rd & (address == AddrPeriod);

   // Only the two low bits of writedata are meaningful in any register.
   assign w_unused_wdata = ^writedata[31:2];

   // ---------------------------------------------------------------------------
   // CTRL
   // ---------------------------------------------------------------------------
   logic r_ctrl_en;
   logic r_ctrl_irq_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl_en     <= 1'b0;
         r_ctrl_irq_en <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_ctrl_en     <= writedata[0];
         r_ctrl_irq_en <= writedata[1];
      end
   end

   // ---------------------------------------------------------------------------
   // Measurement state machine
   // ---------------------------------------------------------------------------
   state_e               r_state;
   logic [CNT_WIDTH-1:0] r_period_cnt;
   logic [CNT_WIDTH-1:0] r_high_cnt;
   logic [CNT_WIDTH-1:0] r_period;
   logic [CNT_WIDTH-1:0] r_high;
   logic                 w_in_measure;
   logic                 w_capture;
   logic                 w_cnt_sat;

   // Events are only honoured while enabled; clearing enable wins over both.
   assign w_in_measure = r_ctrl_en & (r_state == StMeasure);
   assign w_capture    = w_in_measure & w_rise;
   assign w_cnt_sat    = w_in_measure & ~w_rise & (r_period_cnt == CntMax);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         r_period     <= '0;
         r_high       <= '0;
      end else if (!r_ctrl_en) begin
         // Any partial cycle is discarded; PERIOD/HIGH keep their values.
         r_state      <= StIdle;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_state <= StArm;
            end
            StArm: begin
               if (w_rise) begin
                  // The rise cycle itself counts toward both period and high.
                  r_period_cnt <= CntOne;
                  r_high_cnt   <= CntOne;
                  r_state      <= StMeasure;
               end
            end
            StMeasure: begin
               if (w_capture) begin
                  r_period     <= r_period_cnt;
                  r_high       <= r_high_cnt;
                  r_period_cnt <= CntOne;
                  r_high_cnt   <= CntOne;
               end else if (w_cnt_sat) begin
                  // Input stuck high or low: drop back and wait for a fresh rise.
                  r_period_cnt <= '0;
                  r_high_cnt   <= '0;
                  r_state      <= StArm;
               end else begin
                  r_period_cnt <= r_period_cnt + CntOne;
                  r_high_cnt   <= r_high_cnt + {{(CNT_WIDTH-1){1'b0}}, r_s};
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // STATUS (write-1-to-clear, set has priority)
   // ---------------------------------------------------------------------------
   logic r_valid;
   logic r_timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_capture) begin
            r_valid <= 1'b1;
         end else if (w_wr_status && writedata[0]) begin
            r_valid <= 1'b0;
         end

         if (w_cnt_sat) begin
            r_timeout <= 1'b1;
         end else if (w_wr_status && writedata[1]) begin
            r_timeout <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Coherent HIGH shadow and registered read data
   // ---------------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] r_high_shadow;

   // Sampling r_high on the PERIOD read edge pairs it with the PERIOD value
   // returned on that same edge, even if a capture also lands on it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_high_shadow <= '0;
      end else if (w_rd_period) begin
         r_high_shadow <= r_high;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (w_rd) begin
         unique case (address)
            AddrCtrl:   readdata <= {30'd0, r_ctrl_irq_en, r_ctrl_en};
            AddrStatus: readdata <= {30'd0, r_timeout, r_valid};
            AddrPeriod: readdata <= 32'(r_period);
            AddrHigh:   readdata <= 32'(r_high_shadow);
            default:    readdata <= '0;
         endcase
      end
   end

   assign irq = r_valid & r_ctrl_irq_en;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Drives clock-aligned PWM waveforms built from (high, low) cycle counts and
// compares register reads against the expected measurement of the last full
// PWM cycle: PERIOD = high + low, HIGH = high.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

   localparam int unsigned CW     = 8;
   localparam int unsigned CntMax = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        pwm_in;
   logic        irq;

   int total = 0;
   int bad   = 0;

   // Waveform generator controls.
   int wave_hi    = 70;
   int wave_lo    = 30;
   bit wave_on    = 1'b0;
   bit wave_level = 1'b0;
   int rise_cnt   = 0;

   pwm_capture #(
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .pwm_in     (pwm_in),
      .irq        (irq)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: a rise-to-rise window of a (hi, lo) waveform.
   function automatic logic [31:0] ref_period(input int hi, input int lo);
      return 32'(hi + lo);
   endfunction

   function automatic logic [31:0] ref_high(input int hi);
      return 32'(hi);
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      @(negedge clk);
      d          = readdata;
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check_eq(tag, d, exp);
   endtask

   task automatic wait_rises(input string tag, input int target);
      int n;
      n = 0;
      while (rise_cnt < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(rise_cnt >= target), 32'd1);
   endtask

   // PWM driver: pwm_in changes only on falling clock edges.
   initial begin : driver
      int hi;
      int lo;
      pwm_in = 1'b0;
      forever begin
         if (wave_on) begin
            hi = wave_hi;
            lo = wave_lo;
            if (!pwm_in) rise_cnt++;
            pwm_in = 1'b1;
            repeat (hi) @(negedge clk);
            pwm_in = 1'b0;
            repeat (lo) @(negedge clk);
         end else begin
            if (wave_level && !pwm_in) rise_cnt++;
            pwm_in = wave_level;
            @(negedge clk);
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      int h;
      int l;
      int prev_p;
      int r0;

      address    = '0;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      reset_n    = 1'b0;
      #55;
      reset_n    = 1'b1;

      // Reset values
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_rdata", readdata, 32'd0);
      rd_chk("rst_ctrl",   2'd0, 32'd0);
      rd_chk("rst_status", 2'd1, 32'd0);
      rd_chk("rst_period", 2'd2, 32'd0);
      rd_chk("rst_high",   2'd3, 32'd0);

      // Nominal 100/70
      wave_hi = 70;
      wave_lo = 30;
      wave_on = 1'b1;
      bus_write(2'd0, 32'd1);
      wait_cyc(250);
      rd_chk("nom_status", 2'd1, 32'd1);
      rd_chk("nom_period", 2'd2, ref_period(70, 30));
      rd_chk("nom_high",   2'd3, ref_high(70));
      check_eq("nom_irq_dis", 32'(irq), 32'd0);

      // Interrupt and clear
      bus_write(2'd0, 32'd3);
      check_eq("irq_on", 32'(irq), 32'd1);
      bus_write(2'd1, 32'd1);
      n = 0;
      while (!irq && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("irq_rise", 32'(irq), 32'd1);
      bus_write(2'd1, 32'd1);
      check_eq("irq_clr", 32'(irq), 32'd0);
      n = 2;
      while (!irq && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq("irq_gap", 32'(n), ref_period(70, 30));

      // Coherency
      rd_chk("coh_period0", 2'd2, ref_period(70, 30));
      wave_hi = 10;
      wave_lo = 40;
      wait_cyc(300);
      rd_chk("coh_shadow",  2'd3, ref_high(70));
      rd_chk("coh_period1", 2'd2, ref_period(10, 40));
      rd_chk("coh_high1",   2'd3, ref_high(10));

      // Read-only registers ignore writes; CTRL keeps only its two bits
      bus_write(2'd2, $urandom);
      bus_write(2'd3, $urandom);
      rd_chk("ro_period", 2'd2, ref_period(10, 40));
      rd_chk("ro_high",   2'd3, ref_high(10));
      bus_write(2'd0, 32'hFFFF_FFFF);
      rd_chk("ctrl_mask", 2'd0, 32'd3);
      bus_write(2'd0, 32'd1);

      // Timeout: let it saturate while low, then again while held high
      wave_on    = 1'b0;
      wave_level = 1'b0;
      wait_cyc(400);
      bus_write(2'd1, 32'd3);
      rd_chk("to_clear", 2'd1, 32'd0);
      wave_level = 1'b1;
      wait_cyc(CntMax - 20);
      rd_chk("to_early", 2'd1, 32'd0);
      wait_cyc(30);
      rd_chk("to_set",    2'd1, 32'd2);
      rd_chk("to_period", 2'd2, ref_period(10, 40));

      // Recovery from ARM after a timeout
      wave_hi = 40;
      wave_lo = 20;
      wave_on = 1'b1;
      wait_cyc(250);
      rd_chk("arm_status", 2'd1, 32'd3);
      rd_chk("arm_period", 2'd2, ref_period(40, 20));
      rd_chk("arm_high",   2'd3, ref_high(40));

      // Randomized waveforms
      prev_p = 60;
      for (int i = 0; i < 8; i++) begin
         h = int'($urandom_range(2, 80));
         l = int'($urandom_range(2, 80));
         wave_hi = h;
         wave_lo = l;
         wait_cyc(prev_p + 2 * (h + l) + 10);
         bus_write(2'd1, 32'd3);
         wait_cyc(h + l + 10);
         rd_chk("rnd_status", 2'd1, 32'd1);
         rd_chk("rnd_period", 2'd2, ref_period(h, l));
         rd_chk("rnd_high",   2'd3, ref_high(h));
         prev_p = h + l;
      end

      // Disable mid-measurement
      wave_hi = 70;
      wave_lo = 30;
      wait_cyc(prev_p + 210);
      r0 = rise_cnt;
      wait_rises("dis_sync", r0 + 1);
      wait_cyc(50);
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'd0);
      wait_cyc(10);
      bus_write(2'd0, 32'd3);
      r0 = rise_cnt;
      wait_rises("dis_rise1", r0 + 1);
      wait_cyc(6);
      rd_chk("dis_nocap", 2'd1, 32'd0);
      rd_chk("dis_held",  2'd2, ref_period(70, 30));
      wait_rises("dis_rise2", r0 + 2);
      wait_cyc(6);
      rd_chk("dis_cap",  2'd1, 32'd1);
      check_eq("dis_irq", 32'(irq), 32'd1);
      rd_chk("dis_period", 2'd2, ref_period(70, 30));
      rd_chk("dis_high",   2'd3, ref_high(70));

      // Reset mid-MEASURE
      wait_cyc(37);
      #3;
      reset_n = 1'b0;
      #40;
      reset_n = 1'b1;
      check_eq("mrst_irq",   32'(irq), 32'd0);
      check_eq("mrst_rdata", readdata, 32'd0);
      rd_chk("mrst_ctrl",   2'd0, 32'd0);
      rd_chk("mrst_status", 2'd1, 32'd0);
      rd_chk("mrst_period", 2'd2, 32'd0);
      rd_chk("mrst_high",   2'd3, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Avalon-MM slave that measures an external PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the `pwm` generator slave. It sits on the same bus fabric and is used to close the loop on generated PWM outputs, or to decode PWM from external sensors and drivers. Measurements are coherent: the period and high time returned together always come from the same PWM cycle.

## Interface
- `CNT_WIDTH`, default 32: width of the period and high counters, 8..32. Register fields are zero-extended to 32 bits.
- `clk`, input, 1: single system clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `address`, input, 2: register select. 0 = CTRL, 1 = STATUS, 2 = PERIOD, 3 = HIGH.
- `chipselect`, input, 1: qualifies `read` and `write`.
- `read`, input, 1: read strobe.
- `write`, input, 1: write strobe.
- `writedata`, input, 32: write data.
- `readdata`, output, 32: registered read data.
- `pwm_in`, input, 1: asynchronous PWM input under measurement.
- `irq`, output, 1: level interrupt, equal to `STATUS.valid & CTRL.irq_en`.

## Operation
- Input path:
  - `pwm_in` passes through a 2-flop synchronizer to produce `s`.
  - A further flop produces `s_d`.
  - A rising edge is `rise = s & ~s_d`.
- CTRL (RW, reset 0):
  - bit0 `enable`.
  - bit1 `irq_en`.
  - Other bits read 0.
- STATUS (reset 0):
  - bit0 `valid`: a new measurement has been captured.
  - bit1 `timeout`: the counter saturated before the next edge.
  - Writing 1 to a bit clears it; writing 0 has no effect.
  - If a set event and a clear land in the same cycle, the set wins.
- PERIOD, HIGH (RO, reset 0): writes to these addresses are ignored.
- State machine:
  - IDLE:
    - Entered on reset or when `enable`=0.
    - Counters are held at 0.
    - Goes to ARM when `enable`=1.
  - ARM: waits for `rise`. On `rise`, loads `period_cnt`=1 and `high_cnt`=1, then goes to MEASURE.
  - MEASURE, every cycle without `rise`:
    - `period_cnt` += 1.
    - `high_cnt` += `s`.
  - MEASURE, on `rise`:
    - PERIOD <= `period_cnt`.
    - HIGH <= `high_cnt`.
    - Set `valid`.
    - Reload both counters to 1 and stay in MEASURE.
  - MEASURE, when `period_cnt` reaches 2^CNT_WIDTH−1 without `rise`:
    - Set `timeout`.
    - Go to ARM.
    - PERIOD and HIGH keep their last values.
  - This covers a constant-high or constant-low input.
- Measured values:
  - PERIOD is the number of clk cycles from one rise to the next.
  - HIGH is the number of cycles with `s`=1 in that window, counting the first rise cycle and excluding the second.
- Clearing `enable` in any state returns to IDLE on the next edge. The cycle in progress is discarded and PERIOD/HIGH are held.
- Coherency:
  - A read of PERIOD copies the current HIGH into `high_shadow`.
  - A read of HIGH returns `high_shadow`.
  - `high_shadow` resets to 0.
  - Software must read PERIOD first, then HIGH.
- Reset mid-operation:
  - All registers, counters, synchronizer flops, `readdata`, `irq` and the state return to 0 / IDLE immediately.

## Timing
- Reads:
  - On the edge where `chipselect & read`, `readdata` is loaded with the selected register.
  - It is valid from that edge and holds until the next read.
  - Read latency is 1 cycle; there is no waitrequest.
- Writes take effect on the edge where `chipselect & write`.
- Input latency:
  - `pwm_in` rising before clock edge k gives `rise` during the cycle after edge k+1.
  - PERIOD, HIGH and `valid` update at edge k+2.
  - `irq` rises in the same cycle as `valid`.
- Input constraints:
  - Minimum resolvable high or low pulse: 2 clk cycles.
  - Narrower pulses may be missed.
- Input-to-measure jitter is ±1 cycle per edge because of synchronization.

## Test plan
- Reset value checks:
  - Hold `reset_n`=0 for 50 ns.
  - Read all 4 addresses → 0.
  - `irq`=0.
- Nominal duty cycle:
  - 50 MHz clk; write CTRL=1.
  - Drive `pwm_in` with period 100 cycles, high 70 cycles.
  - After the second rise: `valid`=1, read PERIOD=100, then HIGH=70.
- Interrupt and clear:
  - CTRL=3; nominal waveform → `irq`=1.
  - Write STATUS=1 → `irq`=0 next cycle.
  - `irq` reasserts after the next rise.
- Timeout:
  - CNT_WIDTH=8; hold `pwm_in`=1 after one rise.
  - After 255 cycles: STATUS.timeout=1 and the state is ARM.
  - PERIOD is unchanged.
- Coherency:
  - Read PERIOD, which returns 100.
  - Change the waveform to period 50, high 10 and let a capture occur.
  - Read HIGH → 70 (the shadow value).
  - Fresh read of PERIOD then HIGH → 50, 10.
- Disable and reset mid-measurement:
  - Clear `enable` halfway through a cycle.
  - Re-enable: the first capture occurs only after two rises.
  - Pulse `reset_n` low mid-MEASURE → all reads return 0.
